hazard_unit: RTL

- Consumer of the per-stage control bits emitted by the pipeline controller: regwrite, memtoreg, branch, jr and the divide-start decode.
- Returns the hazard controls the datapath and controller need: forwarding selects, stallF/stallD/stallE, flushE (the controller's E-register clear) and flushM.
- Adds a sequential divide-stall FSM that holds the front of the pipeline for a fixed number of cycles while a multi-cycle divide occupies Execute.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_unit_if.sv | 51 +++++
 rtl/hazard_unit_div_stall_fsm.sv | 72 +++++++
 rtl/hazard_unit.sv | 85 ++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: forward-select encodings
// and the divide-stall FSM state encoding.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from Writeback result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from Memory-stage ALU result

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } divState_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of per-stage control/register fields going into the hazard unit and
// the forwarding/stall controls coming back out of it.
interface hazard_unit_if;

  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  logic [4:0] writeregE;
  logic [4:0] writeregM;
  logic [4:0] writeregW;
  logic       regwriteE;
  logic       regwriteM;
  logic       regwriteW;
  logic       memtoregE;
  logic       memtoregM;
  logic       branchD;
  logic       jrD;
  logic       div_startE;

  logic       forwardAD;
  logic       forwardBD;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushE;
  logic       flushM;
  logic       div_busy;
  logic       div_done;

  // Pipeline/controller side: drives stage fields, consumes hazard controls.
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, jrD, div_startE,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
           stallF, stallD, stallE, flushE, flushM, div_busy, div_done
  );

  // Hazard unit side.
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, jrD, div_startE,
    output forwardAD, forwardBD, forwardAE, forwardBE,
           stallF, stallD, stallE, flushE, flushM, div_busy, div_done
  );

endinterface

// File: rtl/hazard_unit_div_stall_fsm.sv
// Divide-stall sequencer: holds the front of the pipeline for DIV_CYCLES
// cycles while a multi-cycle divide sits in Execute, then spends one DONE
// cycle in which the divide is allowed to advance.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic divStart,
  output logic divStall,
  output logic divBusy,
  output logic divDone
);

  // The IDLE cycle that sees divStart already stalls, so BUSY only needs to
  // cover DIV_CYCLES-1 further cycles (counter runs LOAD..0 inclusive).
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  divState_e        stateReg;
  logic [CNT_W-1:0] cntReg;
  logic             busyReg;
  logic             doneReg;

  // State, counter and registered busy/done flags advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (divStart) begin
            stateReg <= BUSY;
            cntReg   <= CNT_LOAD;
            busyReg  <= 1'b1;
          end
        end
        BUSY: begin
          if (cntReg != '0) begin
            cntReg <= cntReg - 1'b1;
          end else begin
            stateReg <= DONE;
            doneReg  <= 1'b1;
          end
        end
        // The divide that finished is still in E here, so its start bit is
        // deliberately ignored; a following divide is picked up from IDLE.
        DONE: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
          doneReg  <= 1'b0;
        end
        default: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
          doneReg  <= 1'b0;
        end
      endcase
    end
  end

  // Stall starts in the same cycle the divide is seen, with no added latency.
  assign divStall = ((stateReg == IDLE) && divStart) || (stateReg == BUSY);
  assign divBusy  = busyReg;
  assign divDone  = doneReg;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects for Decode and Execute, load-use
// and branch-operand stalls, and divide stalls from the div_stall_fsm.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hz
);

  logic divStall;
  logic lwStall;
  logic branchStall;
  logic rsBranchHit;
  logic rtBranchHit;
  logic [1:0] fwdSel [2];

  div_stall_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) uDivFsm (
    .clk      (clk),
    .rst      (rst),
    .divStart (hz.div_startE),
    .divStall (divStall),
    .divBusy  (hz.div_busy),
    .divDone  (hz.div_done)
  );

  // Execute operand selects: M result has priority over W; register 0 never forwards.
  for (genvar gi = 0; gi < 2; gi++) begin : gFwdE
    logic [4:0] srcE;
    assign srcE = (gi == 0) ? hz.rsE : hz.rtE;
    always_comb begin
      fwdSel[gi] = FWD_RF;
      if ((srcE != 5'd0) && hz.regwriteM && (hz.writeregM == srcE))
        fwdSel[gi] = FWD_MEM;
      else if ((srcE != 5'd0) && hz.regwriteW && (hz.writeregW == srcE))
        fwdSel[gi] = FWD_WB;
    end
  end

  assign hz.forwardAE = fwdSel[0];
  assign hz.forwardBE = fwdSel[1];

  // Decode comparator operands can only be bypassed from the M ALU result.
  assign hz.forwardAD = (hz.rsD != 5'd0) && hz.regwriteM && (hz.writeregM == hz.rsD);
  assign hz.forwardBD = (hz.rtD != 5'd0) && hz.regwriteM && (hz.writeregM == hz.rtD);

  // Load in E whose destination feeds the instruction in D.
  assign lwStall = hz.memtoregE &&
                   (((hz.rsD != 5'd0) && (hz.writeregE == hz.rsD)) ||
                    ((hz.rtD != 5'd0) && (hz.writeregE == hz.rtD)));

  // A branch/jr operand still being produced in E, or being loaded in M,
  // cannot be resolved in Decode this cycle.
  assign rsBranchHit = (hz.rsD != 5'd0) &&
                       ((hz.regwriteE && (hz.writeregE == hz.rsD)) ||
                        (hz.memtoregM && (hz.writeregM == hz.rsD)));
  assign rtBranchHit = (hz.rtD != 5'd0) &&
                       ((hz.regwriteE && (hz.writeregE == hz.rtD)) ||
                        (hz.memtoregM && (hz.writeregM == hz.rtD)));
  assign branchStall = (hz.branchD && (rsBranchHit || rtBranchHit)) ||
                       (hz.jrD && rsBranchHit);

  // Divide holds F/D/E and bubbles M; otherwise stall the front and bubble E.
  always_comb begin
    hz.stallF = lwStall || branchStall;
    hz.stallD = lwStall || branchStall;
    hz.flushE = lwStall || branchStall;
    hz.stallE = 1'b0;
    hz.flushM = 1'b0;
    if (divStall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.flushE = 1'b0;
      hz.flushM = 1'b1;
    end
  end

endmodule
